// File: rtl/display_scan_arbiter.sv
// Shared 4-digit 7-segment scan driver: source arbitration, digit multiplexing with blanking, blink and alarm flash.
// Optional LEADING_ZERO_BLANK_EN: blank a zero in the leftmost digit while the alarm is not flashing.
module display_scan_arbiter #(
   parameter int SCAN_DIV  = 2048,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_DIV = 32
) (
   input  logic        clk_osc,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [15:0] bcd_src0,
   input  logic [15:0] bcd_src1,
   input  logic [15:0] bcd_src2,
   input  logic [15:0] bcd_src3,
   input  logic [15:0] bcd_time,
   input  logic [3:0]  blink_mask0,
   input  logic [3:0]  blink_mask1,
   input  logic        alarm_flash,
   output logic [3:0]  anode,
   output logic [6:0]  seg,
   output logic [4:0]  grant,
   output logic        frame_tick
);
   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int FRM_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   typedef enum logic {ST_BLANK, ST_DRIVE} state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] slot_cnt_q, slot_cnt_d;
   logic [1:0]       digit_q, digit_d;
   logic [FRM_W-1:0] frame_cnt_q, frame_cnt_d;
   logic             phase_q, phase_d;
   logic [4:0]       grant_q, grant_d;
   logic [3:0]       anode_q, anode_d;
   logic [6:0]       seg_q, seg_d;

   logic             slot_wrap, frame_end, blink_off;
   logic [15:0]      bcd_sel;
   logic [3:0]       mask_sel, nibble, digit_en;
   logic [6:0]       dec_seg;

   function automatic logic [6:0] decode7(input logic [3:0] n);
      case (n)
         4'd0:    decode7 = 7'b1000000;
         4'd1:    decode7 = 7'b1111001;
         4'd2:    decode7 = 7'b0100100;
         4'd3:    decode7 = 7'b0110000;
         4'd4:    decode7 = 7'b0011001;
         4'd5:    decode7 = 7'b0010010;
         4'd6:    decode7 = 7'b0000010;
         4'd7:    decode7 = 7'b1111000;
         4'd8:    decode7 = 7'b0000000;
         4'd9:    decode7 = 7'b0010000;
         default: decode7 = 7'b1111111;
      endcase
   endfunction

   function automatic logic [4:0] pick_grant(input logic [3:0] r);
      if (r[0])      pick_grant = 5'b00001;
      else if (r[1]) pick_grant = 5'b00010;
      else if (r[2]) pick_grant = 5'b00100;
      else if (r[3]) pick_grant = 5'b01000;
      else           pick_grant = 5'b10000;
   endfunction

   // Scan timing, frame-aligned arbitration and blink phase
   always_comb begin
      slot_wrap   = (slot_cnt_q == CNT_W'(SCAN_DIV - 1));
      frame_end   = slot_wrap && (digit_q == 2'd3);
      slot_cnt_d  = slot_wrap ? '0 : slot_cnt_q + 1'b1;
      digit_d     = slot_wrap ? digit_q + 2'd1 : digit_q;
      grant_d     = frame_end ? pick_grant(req) : grant_q;
      frame_cnt_d = frame_cnt_q;
      phase_d     = phase_q;
      if (frame_end) begin
         if (frame_cnt_q == FRM_W'(BLINK_DIV - 1)) begin
            frame_cnt_d = '0;
            phase_d     = ~phase_q;
         end else begin
            frame_cnt_d = frame_cnt_q + 1'b1;
         end
      end
   end

   // Content of the current digit from the granted source
   always_comb begin
      bcd_sel  = bcd_time;
      mask_sel = 4'b0000;
      if (grant_q[0]) begin
         bcd_sel  = bcd_src0;
         mask_sel = blink_mask0;
      end else if (grant_q[1]) begin
         bcd_sel  = bcd_src1;
         mask_sel = blink_mask1;
      end else if (grant_q[2]) begin
         bcd_sel  = bcd_src2;
      end else if (grant_q[3]) begin
         bcd_sel  = bcd_src3;
      end
      case (digit_q)
         2'd0:    nibble = bcd_sel[3:0];
         2'd1:    nibble = bcd_sel[7:4];
         2'd2:    nibble = bcd_sel[11:8];
         default: nibble = bcd_sel[15:12];
      endcase
      dec_seg = decode7(nibble);
`ifdef LEADING_ZERO_BLANK_EN
      if (digit_q == 2'd3 && nibble == 4'd0) dec_seg = 7'b1111111;
`else
`endif
      blink_off = mask_sel[digit_q] && phase_q;
      digit_en  = ~(4'b0001 << digit_q);
   end

   // Outputs are loaded once per slot at DRIVE entry, so mid-slot input changes never show
   always_comb begin
      state_d = state_q;
      anode_d = anode_q;
      seg_d   = seg_q;
      case (state_q)
         ST_BLANK: begin
            if (slot_cnt_q == CNT_W'(BLANK_CYC)) begin
               state_d = ST_DRIVE;
               if (alarm_flash) begin
                  anode_d = digit_en;
                  seg_d   = phase_q ? 7'b0000000 : 7'b1111111;
               end else if (blink_off) begin
                  anode_d = 4'b1111;
                  seg_d   = 7'b1111111;
               end else begin
                  anode_d = digit_en;
                  seg_d   = dec_seg;
               end
            end
         end
         ST_DRIVE: begin
            if (slot_wrap) begin
               state_d = ST_BLANK;
               anode_d = 4'b1111;
               seg_d   = 7'b1111111;
            end
         end
         default: state_d = ST_BLANK;
      endcase
   end

   always_ff @(posedge clk_osc or posedge reset) begin
      if (reset) begin
         state_q     <= ST_BLANK;
         slot_cnt_q  <= '0;
         digit_q     <= 2'd0;
         frame_cnt_q <= '0;
         phase_q     <= 1'b0;
         grant_q     <= 5'b10000;
         anode_q     <= 4'b1111;
         seg_q       <= 7'b1111111;
      end else begin
         state_q     <= state_d;
         slot_cnt_q  <= slot_cnt_d;
         digit_q     <= digit_d;
         frame_cnt_q <= frame_cnt_d;
         phase_q     <= phase_d;
         grant_q     <= grant_d;
         anode_q     <= anode_d;
         seg_q       <= seg_d;
      end
   end

   assign anode      = anode_q;
   assign seg        = seg_q;
   assign grant      = grant_q;
   assign frame_tick = frame_end;

endmodule

// File: tb/tb_display_scan_arbiter.sv
// Bench for display_scan_arbiter: directed scenarios plus random input churn against a cycle-count reference model.
module tb_display_scan_arbiter;
   localparam int SD = 8;
   localparam int BC = 2;
   localparam int BD = 2;
   localparam int FR = 4 * SD;
   localparam logic [6:0] SEG_TAB [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                            7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                            7'b0000000, 7'b0010000};

   logic        clk_osc = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = 4'b0000;
   logic [15:0] bcd_src0 = 16'h0, bcd_src1 = 16'h0, bcd_src2 = 16'h0, bcd_src3 = 16'h0;
   logic [15:0] bcd_time = 16'h1234;
   logic [3:0]  blink_mask0 = 4'b0000, blink_mask1 = 4'b0000;
   logic        alarm_flash = 1'b0;
   logic [3:0]  anode;
   logic [6:0]  seg;
   logic [4:0]  grant;
   logic        frame_tick;

   int compared = 0;
   int mismatched = 0;
   int n = 0;
   logic [3:0] e_anode = 4'b1111;
   logic [6:0] e_seg = 7'b1111111;
   logic [4:0] e_grant = 5'b10000;
   logic       e_tick = 1'b0;

   display_scan_arbiter #(.SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
      .clk_osc(clk_osc), .reset(reset), .req(req),
      .bcd_src0(bcd_src0), .bcd_src1(bcd_src1), .bcd_src2(bcd_src2), .bcd_src3(bcd_src3),
      .bcd_time(bcd_time), .blink_mask0(blink_mask0), .blink_mask1(blink_mask1),
      .alarm_flash(alarm_flash), .anode(anode), .seg(seg), .grant(grant), .frame_tick(frame_tick)
   );

   always #5 clk_osc = ~clk_osc;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, n);
      end
   endtask

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      int idx;
      idx = int'(d);
      return (idx < 10) ? SEG_TAB[idx] : 7'b1111111;
   endfunction

   function automatic logic [4:0] ref_grant(input logic [3:0] r);
      for (int i = 0; i < 4; i++)
         if (r[i]) return 5'(1 << i);
      return 5'b10000;
   endfunction

   task automatic model_reset();
      n = 0;
      e_anode = 4'b1111;
      e_seg = 7'b1111111;
      e_grant = 5'b10000;
      e_tick = 1'b0;
   endtask

   // Expected outputs after clock edge number n since reset release
   task automatic model_edge();
      int cnt, dig, frm;
      logic ph;
      logic [15:0] src;
      logic [3:0] mask, nib;
      n++;
      cnt = n % SD;
      dig = (n / SD) % 4;
      frm = n / FR;
      ph = ((frm / BD) % 2) == 1;
      if (n % FR == 0) e_grant = ref_grant(req);
      e_tick = (n % FR) == FR - 1;
      if (cnt == 0) begin
         e_anode = 4'b1111;
         e_seg = 7'b1111111;
      end else if (cnt == BC + 1) begin
         src = bcd_time;
         mask = 4'b0000;
         if (e_grant == 5'b00001) begin src = bcd_src0; mask = blink_mask0; end
         if (e_grant == 5'b00010) begin src = bcd_src1; mask = blink_mask1; end
         if (e_grant == 5'b00100) src = bcd_src2;
         if (e_grant == 5'b01000) src = bcd_src3;
         nib = 4'((src >> (4 * dig)) & 16'hF);
         if (alarm_flash) begin
            e_anode = ~(4'b0001 << dig);
            e_seg = ph ? 7'b0000000 : 7'b1111111;
         end else if (mask[dig] && ph) begin
            e_anode = 4'b1111;
            e_seg = 7'b1111111;
         end else begin
            e_anode = ~(4'b0001 << dig);
            e_seg = ref_seg(nib);
`ifdef LEADING_ZERO_BLANK_EN
            if (dig == 3 && nib == 4'd0) e_seg = 7'b1111111;
`endif
         end
      end
   endtask

   task automatic step();
      @(posedge clk_osc);
      model_edge();
      @(negedge clk_osc);
      check("anode", 16'(anode), 16'(e_anode));
      check("seg", 16'(seg), 16'(e_seg));
      check("grant", 16'(grant), 16'(e_grant));
      check("frame_tick", 16'(frame_tick), 16'(e_tick));
   endtask

   task automatic run(input int k);
      for (int i = 0; i < k; i++) step();
   endtask

   task automatic perturb();
      if ($urandom_range(0, 39) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_src0 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_src1 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_src2 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_src3 = 16'($urandom);
      if ($urandom_range(0, 7) == 0) bcd_time = 16'($urandom);
      if ($urandom_range(0, 31) == 0) blink_mask0 = 4'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 31) == 0) blink_mask1 = 4'(1 << $urandom_range(0, 4));
      if ($urandom_range(0, 63) == 0) alarm_flash = ~alarm_flash;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_anode"}, 16'(anode), 16'h000F);
      check({tag, "_seg"}, 16'(seg), 16'h007F);
      check({tag, "_grant"}, 16'(grant), 16'h0010);
      check({tag, "_tick"}, 16'(frame_tick), 16'h0000);
   endtask

   initial begin
      #12;
      check_reset_values("por");
      @(negedge clk_osc);
      reset = 1'b0;
      model_reset();

      // Current time by default: rightmost "4", leftmost "1"
      run(BC + 1);
      check("d0_anode", 16'(anode), 16'h000E);
      check("d0_seg", 16'(seg), 16'(7'b0011001));
      run(3 * SD);
      check("d3_anode", 16'(anode), 16'h0007);
      check("d3_seg", 16'(seg), 16'(7'b1111001));
      run(FR + (FR - 1 - n % FR));
      check("tick_at_frame_end", 16'(frame_tick), 16'h0001);

      // Source request raised mid-frame waits for the frame boundary
      run(FR / 2 + 1);
      req = 4'b0100;
      bcd_src2 = 16'h0507;
      run(FR / 2 - 2);
      check("grant_held", 16'(grant), 16'h0010);
      run(2 * FR);

      // src0 wins over src1; digit1 blinks
      req = 4'b0011;
      bcd_src0 = 16'h9999;
      blink_mask0 = 4'b0010;
      run(6 * FR);

      // Alarm flash over an all-zero time
      req = 4'b0000;
      bcd_time = 16'h0000;
      alarm_flash = 1'b1;
      run(5 * FR);
      alarm_flash = 1'b0;
      run(FR);

      // Random churn, including mid-slot changes
      for (int i = 0; i < 40 * FR; i++) begin
         perturb();
         step();
      end

      // Undecodable nibble, then asynchronous reset in the middle of a slot
      req = 4'b0000;
      alarm_flash = 1'b0;
      bcd_time = 16'h0A00;
      run(FR + 2 * SD + BC + 3);
      #2 reset = 1'b1;
      #1 check_reset_values("mid_reset");
      @(negedge clk_osc);
      check_reset_values("held_reset");
      reset = 1'b0;
      model_reset();
      run(2 * FR);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end
endmodule
